// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 16-word block, then streams W_0..W_{NUM_ROUNDS-1}
// from a 16-deep shift window expanded in place with sigma0/sigma1.
module sha256_msg_schedule #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_word,
    output logic [5:0]  w_index,
    output logic        w_last
);

    typedef enum logic {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

    state_t      state_reg, state_next;
    logic [3:0]  lcnt_reg, lcnt_next;
    logic [5:0]  t_reg, t_next;
    logic [31:0] win_reg  [16];
    logic [31:0] win_next [16];

    logic        in_acc;
    logic        w_acc;
    logic        shift_en;
    logic [31:0] expand_word;
    logic [31:0] new_word;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign in_ready = (state_reg == LOAD);
    assign w_valid  = (state_reg == STREAM);
    assign w_word   = w_valid ? win_reg[0] : 32'h0;
    assign w_index  = t_reg;
    assign w_last   = w_valid & (t_reg == LAST_T);

    // flush wins over both handshakes, so neither side may complete a transfer with it
    assign in_acc   = in_valid & in_ready & ~flush;
    assign w_acc    = w_valid & w_ready & ~flush;
    assign shift_en = in_acc | w_acc;

    // win[15] slot after the shift: taps are offsets t-2, t-7, t-15, t-16 relative to the new word
    assign expand_word = sigma1(win_reg[14]) + win_reg[9] + sigma0(win_reg[1]) + win_reg[0];
    assign new_word    = in_acc ? in_word : expand_word;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_win
            if (gi < 15) begin : g_mid
                assign win_next[gi] = flush    ? 32'h0 :
                                      shift_en ? win_reg[gi + 1] : win_reg[gi];
            end else begin : g_top
                assign win_next[gi] = flush    ? 32'h0 :
                                      shift_en ? new_word : win_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        lcnt_next  = lcnt_reg;
        t_next     = t_reg;
        if (flush) begin
            state_next = LOAD;
            lcnt_next  = 4'd0;
            t_next     = 6'd0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (in_acc) begin
                        lcnt_next = lcnt_reg + 4'd1;
                        if (lcnt_reg == 4'd15) begin
                            state_next = STREAM;
                            t_next     = 6'd0;
                        end
                    end
                end
                STREAM: begin
                    if (w_acc) begin
                        if (t_reg == LAST_T) begin
                            state_next = LOAD;
                            lcnt_next  = 4'd0;
                            t_next     = 6'd0;
                        end else begin
                            t_next = t_reg + 6'd1;
                        end
                    end
                end
                default: state_next = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= LOAD;
            lcnt_reg  <= 4'd0;
            t_reg     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_reg[i] <= 32'h0;
            end
        end else begin
            state_reg <= state_next;
            lcnt_reg  <= lcnt_next;
            t_reg     <= t_next;
            for (int i = 0; i < 16; i++) begin
                win_reg[i] <= win_next[i];
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboarded bench for sha256_msg_schedule: a FIPS-style array model predicts W_t,
// a negedge monitor compares every presented word and pops on accept.
module tb_sha256_msg_schedule;

    localparam int NR = 64;

    typedef logic [31:0] blk_t [16];
    typedef struct {
        logic [31:0] w;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_word;
    logic [5:0]  w_index;
    logic        w_last;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          stall = 1'b0;
    exp_t        q[$];
    logic [31:0] got [NR];

    sha256_msg_schedule #(.NUM_ROUNDS(NR)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_word   (w_word),
        .w_index  (w_index),
        .w_last   (w_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: the textbook 64-entry array expansion
    task automatic push_expected(input blk_t m);
        logic [31:0] w [64];
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w[t] = m[t];
            end else begin
                s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
        end
        for (int t = 0; t < NR; t++) begin
            q.push_back('{w[t], 6'(t), (t == NR - 1)});
        end
        $display("scoreboard: queued %0d words, W0=%h", NR, w[0]);
    endtask

    always @(negedge clk) begin
        if (reset_n && !flush && w_valid) begin
            if (q.size() == 0) begin
                timeout("unexpected_w_valid");
            end else begin
                check("w_word", w_word, q[0].w);
                check("w_index", 32'(w_index), 32'(q[0].idx));
                check("w_last", 32'(w_last), 32'(q[0].last));
                if (w_ready) begin
                    got[w_index] = w_word;
                    $display("accept W[%0d] = %h last=%0b", w_index, w_word, w_last);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            w_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic clear_got();
        for (int i = 0; i < NR; i++) got[i] = 32'hdeadbeef;
    endtask

    task automatic load_block(input blk_t m, input bit gaps, input int count);
        int c;
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_word  = $urandom;
                    @(posedge clk);
                    #1;
                end
            end
            c = 0;
            while (!in_ready && c < 200) begin
                @(posedge clk);
                #1;
                c++;
            end
            if (!in_ready) timeout("in_ready_wait");
            in_valid = 1'b1;
            in_word  = m[i];
            @(posedge clk);
            #1;
            if (i < 15) check("no_early_stream", 32'(w_valid), 32'd0);
        end
        in_valid = 1'b0;
        in_word  = $urandom;
        if (count == 16) begin
            push_expected(m);
            check("w0_latency_valid", 32'(w_valid), 32'd1);
            check("w0_latency_index", 32'(w_index), 32'd0);
            check("in_ready_in_stream", 32'(in_ready), 32'd0);
        end
    endtask

    task automatic drain();
        int c = 0;
        while (q.size() != 0 && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (q.size() != 0) begin
            timeout("drain");
            q.delete();
        end
        check("in_ready_after_last", 32'(in_ready), 32'd1);
        check("w_valid_after_last", 32'(w_valid), 32'd0);
    endtask

    task automatic wait_index(input int n);
        int c = 0;
        while (!(w_valid && w_index == 6'(n)) && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (!(w_valid && w_index == 6'(n))) timeout("wait_index");
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_w_valid", 32'(w_valid), 32'd0);
    endtask

    initial begin
        blk_t abc, zero, rnd;
        for (int i = 0; i < 16; i++) begin
            abc[i]  = 32'h0;
            zero[i] = 32'h0;
        end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        reset_n  = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_word  = 32'h0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_w_valid", 32'(w_valid), 32'd0);
        check("rst_w_word", w_word, 32'h0);
        check("rst_w_index", 32'(w_index), 32'd0);
        check("rst_w_last", 32'(w_last), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // abc, full throughput
        clear_got();
        load_block(abc, 1'b0, 16);
        drain();
        check("abc_W0", got[0], 32'h61626380);
        check("abc_W15", got[15], 32'h00000018);
        check("abc_W16", got[16], 32'h61626380);
        check("abc_W17", got[17], 32'h000F0000);

        // all-zero block with input gaps
        clear_got();
        load_block(zero, 1'b1, 16);
        drain();
        check("zero_W63", got[63], 32'h0);

        // abc under backpressure
        clear_got();
        stall = 1'b1;
        load_block(abc, 1'b0, 16);
        drain();
        check("stall_W17", got[17], 32'h000F0000);

        // random blocks, gaps and stalls
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++) rnd[i] = $urandom;
            load_block(rnd, 1'b1, 16);
            drain();
        end
        stall = 1'b0;

        // flush during load (word offered in the flush cycle must be dropped)
        load_block(abc, 1'b0, 7);
        in_valid = 1'b1;
        in_word  = 32'hffffffff;
        do_flush();

        // flush mid-stream
        load_block(abc, 1'b0, 16);
        wait_index(30);
        do_flush();

        clear_got();
        load_block(abc, 1'b1, 16);
        drain();
        check("post_flush_W17", got[17], 32'h000F0000);

        // asynchronous reset mid-stream
        load_block(abc, 1'b0, 16);
        wait_index(20);
        reset_n = 1'b0;
        #1;
        check("async_rst_w_valid", 32'(w_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_w_word", w_word, 32'h0);
        check("async_rst_w_index", 32'(w_index), 32'd0);
        q.delete();
        #1;
        reset_n = 1'b1;
        clear_got();
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        load_block(rnd, 1'b1, 16);
        drain();
        check("post_rst_W0", got[0], rnd[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
